// File: rtl/image_stream_source.sv
// -----------------------------------------------------------------------------
// image_stream_source
//
// Raster-order pixel transmitter. Reads one frame from a synchronous frame
// memory (1-cycle read latency) and streams it to the 2-D filter input at one
// pixel per cycle. HBLANK idle cycles are inserted between lines, and the
// stream stalls while the filter's process_enable is low.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active-low
//   start          in   1-cycle pulse, begins one frame (only honoured in IDLE)
//   abort          in   synchronous return to IDLE, beats everything but rst
//   process_enable in   filter ready; low stalls the stream
//   mem_rd_en      out  frame memory read strobe
//   mem_addr       out  frame memory read address (row*COLS+col)
//   mem_rd_data    in   read data, valid one cycle after mem_rd_en
//   pix_valid      out  pixel valid (filter data_in_valid)
//   pix_data       out  pixel value (filter data_in)
//   pix_x, pix_y   out  column / row of the pixel on pix_data
//   busy           out  high from the cycle after an accepted start through
//                       the frame_done cycle
//   frame_done     out  1-cycle pulse coincident with the last pixel
// -----------------------------------------------------------------------------
module image_stream_source #(
   parameter int  BITWIDTH = 8,
   parameter int  COLS     = 640,
   parameter int  ROWS     = 480,
   parameter int  HBLANK   = 4,
   localparam int AW       = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1,
   localparam int XW       = $clog2(COLS) + 1,
   localparam int YW       = $clog2(ROWS) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                process_enable,
   output logic                mem_rd_en,
   output logic [AW-1:0]       mem_addr,
   input  logic [BITWIDTH-1:0] mem_rd_data,
   output logic                pix_valid,
   output logic [BITWIDTH-1:0] pix_data,
   output logic [XW-1:0]       pix_x,
   output logic [YW-1:0]       pix_y,
   output logic                busy,
   output logic                frame_done
);

   localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

   localparam logic [XW-1:0] COL_LAST   = XW'(COLS - 1);
   localparam logic [YW-1:0] ROW_LAST   = YW'(ROWS - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_EN,
      S_LINE,
      S_HBLANK,
      S_DRAIN
   } state_t;

   state_t              state_q,     state_d;
   logic [XW-1:0]       col_q,       col_d;
   logic [YW-1:0]       row_q,       row_d;
   logic [AW-1:0]       addr_q,      addr_d;
   logic [BW-1:0]       blank_q,     blank_d;
   logic                pix_valid_q, pix_valid_d;
   logic [XW-1:0]       pix_x_q,     pix_x_d;
   logic [YW-1:0]       pix_y_q,     pix_y_d;
   logic [BITWIDTH-1:0] pix_hold_q,  pix_hold_d;
   logic                rd_en;

   // ---- read-issue stage: FSM, raster counters, running address ----
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      addr_d     = addr_q;
      blank_d    = blank_q;
      rd_en      = 1'b0;
      frame_done = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT_EN;
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
            end
         end
         S_WAIT_EN: begin
            if (process_enable) state_d = S_LINE;
         end
         S_LINE: begin
            if (process_enable) begin
               rd_en  = 1'b1;
               // Address advances by one per read; row*COLS+col falls out of
               // raster order without a multiplier.
               addr_d = addr_q + AW'(1);
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     state_d = S_DRAIN;
                  end else if (HBLANK == 0) begin
                     row_d = row_q + YW'(1);
                  end else begin
                     state_d = S_HBLANK;
                     blank_d = '0;
                  end
               end else begin
                  col_d = col_q + XW'(1);
               end
            end
         end
         S_HBLANK: begin
            // Blanking runs regardless of process_enable.
            if (blank_q == BLANK_LAST) begin
               state_d = S_LINE;
               row_d   = row_q + YW'(1);
            end else begin
               blank_d = blank_q + BW'(1);
            end
         end
         S_DRAIN: begin
            // Last read was issued last cycle; its pixel is on the output now.
            frame_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d    = S_IDLE;
         col_d      = '0;
         row_d      = '0;
         addr_d     = '0;
         blank_d    = '0;
         frame_done = 1'b0;
      end
   end

   // ---- pixel output stage: one cycle behind the read ----
   always_comb begin
      // A read issued in the abort cycle is dropped.
      pix_valid_d = rd_en & ~abort;
      pix_x_d     = pix_valid_d ? col_q : pix_x_q;
      pix_y_d     = pix_valid_d ? row_q : pix_y_q;
      pix_hold_d  = pix_valid_q ? mem_rd_data : pix_hold_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         addr_q      <= '0;
         blank_q     <= '0;
         pix_valid_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         addr_q      <= addr_d;
         blank_q     <= blank_d;
         pix_valid_q <= pix_valid_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         pix_hold_q  <= pix_hold_d;
      end
   end

   // Memory data is passed straight through while valid so the pixel appears
   // one cycle after its read; otherwise the last pixel is held.
   assign pix_data  = pix_valid_q ? mem_rd_data : pix_hold_q;
   assign pix_valid = pix_valid_q;
   assign pix_x     = pix_x_q;
   assign pix_y     = pix_y_q;
   assign mem_rd_en = rd_en;
   assign mem_addr  = addr_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_image_stream_source.sv
// -----------------------------------------------------------------------------
// tb_image_stream_source
//
// Bench for image_stream_source with a 4x3 frame and two blanking cycles.
// A behavioural frame memory holds mem[i] = i + 8'h10. Stimulus pushes the
// expected pixels (arrival cycle, data, coordinates, frame_done) into a queue;
// a monitor pops and compares whenever pix_valid is seen.
// -----------------------------------------------------------------------------
module tb_image_stream_source;

   localparam int BITWIDTH = 8;
   localparam int COLS     = 4;
   localparam int ROWS     = 3;
   localparam int HBLANK   = 2;
   localparam int AW       = 4;
   localparam int XW       = 3;
   localparam int YW       = 3;

   logic                clk;
   logic                rst;
   logic                start;
   logic                abort;
   logic                process_enable;
   logic                mem_rd_en;
   logic [AW-1:0]       mem_addr;
   logic [BITWIDTH-1:0] mem_rd_data;
   logic                pix_valid;
   logic [BITWIDTH-1:0] pix_data;
   logic [XW-1:0]       pix_x;
   logic [YW-1:0]       pix_y;
   logic                busy;
   logic                frame_done;

   image_stream_source #(
      .BITWIDTH (BITWIDTH),
      .COLS     (COLS),
      .ROWS     (ROWS),
      .HBLANK   (HBLANK)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .process_enable (process_enable),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_rd_data    (mem_rd_data),
      .pix_valid      (pix_valid),
      .pix_data       (pix_data),
      .pix_x          (pix_x),
      .pix_y          (pix_y),
      .busy           (busy),
      .frame_done     (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous frame memory, 1-cycle read latency.
   logic [BITWIDTH-1:0] mem [0:15];
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      mem_rd_data = '0;
   end
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

   typedef struct {
      int          cyc;
      logic [7:0]  d;
      logic [2:0]  x;
      logic [2:0]  y;
      logic        fd;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   errors  = 0;
   int   base;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push_pix(input int c, input int idx, input logic fd);
      exp_t e;
      e.cyc = c;
      e.d   = 8'h10 + 8'(idx);
      e.x   = 3'(idx % COLS);
      e.y   = 3'(idx / COLS);
      e.fd  = fd;
      q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every delivered pixel must match the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      if (pix_valid) begin
         if (q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_pixel @cyc %0d: got data %0h, expected no pixel", cyc, pix_data);
         end else begin
            e = q.pop_front();
            chk("pix_cycle", cyc, e.cyc);
            chk("pix_data", pix_data, e.d);
            chk("pix_x", pix_x, e.x);
            chk("pix_y", pix_y, e.y);
            chk("frame_done", frame_done, e.fd);
         end
      end else if (frame_done) begin
         vectors++;
         errors++;
         $display("FAIL frame_done_without_pixel @cyc %0d: got 1, expected 0", cyc);
      end
   end

   initial begin
      rst            = 1'b0;
      start          = 1'b0;
      abort          = 1'b0;
      process_enable = 1'b1;

      // Reset state
      next_cycle();
      @(negedge clk);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_pix_data", pix_data, 0);
      chk("rst_addr", mem_addr, 0);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      next_cycle();

      // Test 1/2: full frame, continuous enable
      base = cyc;
      for (int k = 0; k < 22; k++) begin
         start = (k == 0);
         if (k == 0)
            for (int i = 0; i < 12; i++) push_pix(base + 3 + i + 2 * (i / 4), i, i == 11);
         @(negedge clk);
         case (k)
            0:  chk("t1_busy_c0", busy, 0);
            1:  begin chk("t1_busy_c1", busy, 1); chk("t1_rd_c1", mem_rd_en, 0); end
            2:  begin chk("t1_rd_c2", mem_rd_en, 1); chk("t1_addr_c2", mem_addr, 0); end
            6:  chk("t1_rd_blank_c6", mem_rd_en, 0);
            7:  begin chk("t1_hold_data_c7", pix_data, 8'h13); chk("t1_hold_x_c7", pix_x, 3); end
            8:  begin chk("t1_rd_c8", mem_rd_en, 1); chk("t1_addr_c8", mem_addr, 4); end
            17: chk("t1_addr_c17", mem_addr, 11);
            18: chk("t1_busy_c18", busy, 1);
            19: chk("t1_busy_c19", busy, 0);
            default: ;
         endcase
         next_cycle();
      end
      start = 1'b0;
      chk("t1_queue_empty", q.size(), 0);

      // Test 3: stall during cycles 3-4
      base = cyc;
      for (int k = 0; k < 24; k++) begin
         start          = (k == 0);
         process_enable = !(k == 3 || k == 4);
         if (k == 0)
            for (int i = 0; i < 12; i++)
               push_pix(base + 3 + i + 2 * (i / 4) + ((i >= 1) ? 2 : 0), i, i == 11);
         @(negedge clk);
         case (k)
            3:  begin chk("t3_rd_c3", mem_rd_en, 0); chk("t3_addr_c3", mem_addr, 1); end
            4:  begin chk("t3_rd_c4", mem_rd_en, 0); chk("t3_addr_c4", mem_addr, 1); end
            5:  begin chk("t3_rd_c5", mem_rd_en, 1); chk("t3_addr_c5", mem_addr, 1); end
            20: chk("t3_busy_c20", busy, 1);
            21: chk("t3_busy_c21", busy, 0);
            default: ;
         endcase
         next_cycle();
      end
      start          = 1'b0;
      process_enable = 1'b1;
      chk("t3_queue_empty", q.size(), 0);

      // Test 4: start with enable low, raise at cycle 10
      process_enable = 1'b0;
      base = cyc;
      for (int k = 0; k < 31; k++) begin
         start = (k == 0);
         if (k >= 10) process_enable = 1'b1;
         if (k == 0)
            for (int i = 0; i < 12; i++) push_pix(base + 12 + i + 2 * (i / 4), i, i == 11);
         @(negedge clk);
         case (k)
            5:  begin chk("t4_busy_c5", busy, 1); chk("t4_rd_c5", mem_rd_en, 0); end
            10: chk("t4_rd_c10", mem_rd_en, 0);
            11: begin chk("t4_rd_c11", mem_rd_en, 1); chk("t4_addr_c11", mem_addr, 0); end
            default: ;
         endcase
         next_cycle();
      end
      start = 1'b0;
      chk("t4_queue_empty", q.size(), 0);

      // Test 5: abort at cycle 9, start+abort at 11, restart at 12
      base = cyc;
      for (int k = 0; k < 34; k++) begin
         start = (k == 0 || k == 11 || k == 12);
         abort = (k == 9 || k == 11);
         if (k == 0)
            for (int i = 0; i < 5; i++) push_pix(base + 3 + i + 2 * (i / 4), i, 1'b0);
         if (k == 12)
            for (int i = 0; i < 12; i++) push_pix(base + 15 + i + 2 * (i / 4), i, i == 11);
         @(negedge clk);
         case (k)
            9:  chk("t5_busy_c9", busy, 1);
            10: begin chk("t5_busy_c10", busy, 0); chk("t5_rd_c10", mem_rd_en, 0); end
            12: chk("t5_busy_c12", busy, 0);
            13: chk("t5_busy_c13", busy, 1);
            14: begin chk("t5_rd_c14", mem_rd_en, 1); chk("t5_addr_c14", mem_addr, 0); end
            default: ;
         endcase
         next_cycle();
      end
      start = 1'b0;
      abort = 1'b0;
      chk("t5_queue_empty", q.size(), 0);

      // Test 6: extra start while busy, reset at cycle 7
      base = cyc;
      for (int k = 0; k < 16; k++) begin
         start = (k == 0 || k == 4);
         rst   = !(k == 7 || k == 8);
         if (k == 0)
            for (int i = 0; i < 4; i++) push_pix(base + 3 + i, i, 1'b0);
         @(negedge clk);
         case (k)
            7: begin
               chk("t6_rst_pix_valid", pix_valid, 0);
               chk("t6_rst_rd_en", mem_rd_en, 0);
               chk("t6_rst_busy", busy, 0);
               chk("t6_rst_pix_data", pix_data, 0);
               chk("t6_rst_pix_x", pix_x, 0);
               chk("t6_rst_pix_y", pix_y, 0);
               chk("t6_rst_addr", mem_addr, 0);
            end
            12: chk("t6_busy_c12", busy, 0);
            default: ;
         endcase
         next_cycle();
      end
      start = 1'b0;
      rst   = 1'b1;
      chk("t6_queue_empty", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
